// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution control unit.
// Contents: opcodes, ALU operation codes, FSM state encoding and the R-type decoder.
package conv_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE        = 7'b0110011;
    localparam logic [6:0] OPC_CONV_DEFAULT = 7'b0001011;

    localparam logic [6:0] F7_ZERO = 7'd0;
    localparam logic [6:0] F7_ALT  = 7'd32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_MUL  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_CONV = 4'b1111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONV_RUN = 2'd1,
        CONV_WB  = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] code;
    } rtype_dec_t;

    // Index width for a counter over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Map funct3/funct7 of an R-type instruction to an ALU code.
    function automatic rtype_dec_t decode_rtype(input logic [2:0] funct3,
                                                input logic [6:0] funct7);
        rtype_dec_t d;
        d.legal = 1'b0;
        d.code  = ALU_AND;
        case (funct3)
            3'd0: begin
                if (funct7 == F7_ZERO) begin
                    d.legal = 1'b1;
                    d.code  = ALU_ADD;
                end else if (funct7 == F7_ALT) begin
                    d.legal = 1'b1;
                    d.code  = ALU_SUB;
                end
            end
            3'd1: if (funct7 == F7_ZERO) begin d.legal = 1'b1; d.code = ALU_SLL; end
            3'd2: if (funct7 == F7_ZERO) begin d.legal = 1'b1; d.code = ALU_MUL; end
            3'd4: if (funct7 == F7_ZERO) begin d.legal = 1'b1; d.code = ALU_XOR; end
            3'd5: begin
                if (funct7 == F7_ZERO) begin
                    d.legal = 1'b1;
                    d.code  = ALU_SRL;
                end else if (funct7 == F7_ALT) begin
                    d.legal = 1'b1;
                    d.code  = ALU_SRA;
                end
            end
            3'd6: if (funct7 == F7_ZERO) begin d.legal = 1'b1; d.code = ALU_OR;  end
            3'd7: if (funct7 == F7_ZERO) begin d.legal = 1'b1; d.code = ALU_AND; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Two-level tap/channel counter walking KERNEL_TAPS x NUM_CH positions.
// 'last' flags the final position combinationally from the registered indices.
module conv_tap_counter
    import conv_ctrl_pkg::*;
#(
    parameter int KERNEL_TAPS = 9,
    parameter int NUM_CH      = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              step,
    output logic [idx_width(KERNEL_TAPS)-1:0] tap_index,
    output logic [idx_width(NUM_CH)-1:0]      ch_index,
    output logic                              last
);

    localparam int TAP_W = idx_width(KERNEL_TAPS);
    localparam int CH_W  = idx_width(NUM_CH);

    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(KERNEL_TAPS - 1);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CH - 1);

    logic [TAP_W-1:0] tap_reg;
    logic [CH_W-1:0]  ch_reg;
    logic             tap_last;
    logic             ch_last;

    assign tap_last  = (tap_reg == TAP_MAX);
    assign ch_last   = (ch_reg == CH_MAX);
    assign last      = tap_last & ch_last;
    assign tap_index = tap_reg;
    assign ch_index  = ch_reg;

    // Restart at position 0 on start; otherwise advance taps, carrying into channels.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            tap_reg <= '0;
            ch_reg  <= '0;
        end else if (step) begin
            if (tap_last) begin
                tap_reg <= '0;
                ch_reg  <= ch_last ? '0 : ch_reg + 1'b1;
            end else begin
                tap_reg <= tap_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_control_seq.sv
// Control unit for the convolution datapath: single-cycle R-type decode plus a
// counted accumulate sequence and write-back for the custom convolution opcode.
module conv_control_seq
    import conv_ctrl_pkg::*;
#(
    parameter int         KERNEL_TAPS = 9,
    parameter int         NUM_CH      = 1,
    parameter logic [6:0] CONV_OPCODE = OPC_CONV_DEFAULT
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              instr_valid,
    input  logic [6:0]                        opcode,
    input  logic [2:0]                        funct3,
    input  logic [6:0]                        funct7,
    output logic                              instr_ready,
    output logic [3:0]                        alu_control,
    output logic                              regwrite_control,
    output logic                              acc_clear,
    output logic                              acc_en,
    output logic [idx_width(KERNEL_TAPS)-1:0] tap_index,
    output logic [idx_width(NUM_CH)-1:0]      ch_index,
    output logic                              busy,
    output logic                              done,
    output logic                              illegal_instr
);

    ctrl_state_t state_reg;
    logic [3:0]  alu_reg;
    logic        regwrite_reg;
    logic        acc_clear_reg;
    logic        acc_en_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        illegal_reg;

    logic        accept;
    logic        is_rtype;
    logic        is_conv;
    rtype_dec_t  rdec;
    logic        cnt_start;
    logic        cnt_step;
    logic        cnt_last;

    // Only IDLE accepts, and never while reset is being applied.
    assign instr_ready = (state_reg == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;

    assign is_rtype = (opcode == OPC_RTYPE);
    assign is_conv  = (opcode == CONV_OPCODE) && (funct3 == 3'd0) && (funct7 == F7_ZERO);
    assign rdec     = decode_rtype(funct3, funct7);

    // The counter restarts on a conv accept and advances on every accumulate cycle.
    assign cnt_start = accept && is_conv;
    assign cnt_step  = (state_reg == CONV_RUN);

    conv_tap_counter #(
        .KERNEL_TAPS (KERNEL_TAPS),
        .NUM_CH      (NUM_CH)
    ) u_tap_counter (
        .clock     (clock),
        .reset     (reset),
        .start     (cnt_start),
        .step      (cnt_step),
        .tap_index (tap_index),
        .ch_index  (ch_index),
        .last      (cnt_last)
    );

    // Sequencer FSM; every strobe is registered and defaults low each cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            alu_reg       <= ALU_AND;
            regwrite_reg  <= 1'b0;
            acc_clear_reg <= 1'b0;
            acc_en_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            regwrite_reg  <= 1'b0;
            acc_clear_reg <= 1'b0;
            done_reg      <= 1'b0;
            illegal_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    acc_en_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    if (accept) begin
                        if (is_conv) begin
                            state_reg     <= CONV_RUN;
                            acc_en_reg    <= 1'b1;
                            acc_clear_reg <= 1'b1;
                            busy_reg      <= 1'b1;
                        end else if (is_rtype && rdec.legal) begin
                            alu_reg      <= rdec.code;
                            regwrite_reg <= 1'b1;
                        end else begin
                            illegal_reg <= 1'b1;
                        end
                    end
                end
                CONV_RUN: begin
                    busy_reg <= 1'b1;
                    if (cnt_last) begin
                        state_reg    <= CONV_WB;
                        acc_en_reg   <= 1'b0;
                        alu_reg      <= ALU_CONV;
                        regwrite_reg <= 1'b1;
                        done_reg     <= 1'b1;
                    end else begin
                        acc_en_reg <= 1'b1;
                    end
                end
                CONV_WB: begin
                    state_reg  <= IDLE;
                    acc_en_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
                default: begin
                    state_reg  <= IDLE;
                    acc_en_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign alu_control      = alu_reg;
    assign regwrite_control = regwrite_reg;
    assign acc_clear        = acc_clear_reg;
    assign acc_en           = acc_en_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign illegal_instr    = illegal_reg;

endmodule

// File: tb/tb_conv_control_seq.sv
// Bench for conv_control_seq: a 9x2 instance for decode, sequencing and reset
// abort, plus a 1x1 instance for the single-position corner case.
module tb_conv_control_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance 0: KERNEL_TAPS=9, NUM_CH=2
    logic       v0, rdy0, rw0, clr0, en0, busy0, done0, ill0;
    logic [6:0] op0, f7_0;
    logic [2:0] f3_0;
    logic [3:0] alu0;
    logic [3:0] tap0;
    logic [0:0] ch0;

    // Instance 1: KERNEL_TAPS=1, NUM_CH=1
    logic       v1, rdy1, rw1, clr1, en1, busy1, done1, ill1;
    logic [6:0] op1, f7_1;
    logic [2:0] f3_1;
    logic [3:0] alu1;
    logic [0:0] tap1;
    logic [0:0] ch1;

    conv_control_seq #(.KERNEL_TAPS(9), .NUM_CH(2), .CONV_OPCODE(7'b0001011)) dut0 (
        .clock(clk), .reset(reset), .instr_valid(v0), .opcode(op0), .funct3(f3_0),
        .funct7(f7_0), .instr_ready(rdy0), .alu_control(alu0), .regwrite_control(rw0),
        .acc_clear(clr0), .acc_en(en0), .tap_index(tap0), .ch_index(ch0),
        .busy(busy0), .done(done0), .illegal_instr(ill0)
    );

    conv_control_seq #(.KERNEL_TAPS(1), .NUM_CH(1), .CONV_OPCODE(7'b0001011)) dut1 (
        .clock(clk), .reset(reset), .instr_valid(v1), .opcode(op1), .funct3(f3_1),
        .funct7(f7_1), .instr_ready(rdy1), .alu_control(alu1), .regwrite_control(rw1),
        .acc_clear(clr1), .acc_en(en1), .tap_index(tap1), .ch_index(ch1),
        .busy(busy1), .done(done1), .illegal_instr(ill1)
    );

    localparam logic [6:0] RTYPE = 7'b0110011;
    localparam logic [6:0] CONV  = 7'b0001011;

    typedef struct {
        logic       ready;
        logic [3:0] alu;
        logic       chk_alu;
        logic       rw;
        logic       ill;
        logic       done;
        logic       busy;
        logic       en;
        logic       clr;
        logic       chk_idx;
        int         tap;
        int         ch;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] alu;
        logic       ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input logic rdy, input logic [3:0] alu, input logic chk_alu,
                                input logic rw, input logic ill, input logic dn,
                                input logic bsy, input logic en, input logic clr,
                                input logic chk_idx, input int tap, input int ch);
        exp_t e;
        e.ready = rdy; e.alu = alu; e.chk_alu = chk_alu; e.rw = rw; e.ill = ill;
        e.done = dn; e.busy = bsy; e.en = en; e.clr = clr; e.chk_idx = chk_idx;
        e.tap = tap; e.ch = ch;
        return e;
    endfunction

    function automatic exp_t obs(input int which);
        exp_t o;
        if (which == 0) begin
            o = mk(rdy0, alu0, 1'b1, rw0, ill0, done0, busy0, en0, clr0, 1'b1, int'(tap0), int'(ch0));
        end else begin
            o = mk(rdy1, alu1, 1'b1, rw1, ill1, done1, busy1, en1, clr1, 1'b1, int'(tap1), int'(ch1));
        end
        return o;
    endfunction

    task automatic cmp(input string tag, input string fld, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d expected %0d", tag, fld, act, expv);
        end
    endtask

    task automatic check_rec(input string tag, input exp_t a, input exp_t e);
        cmp(tag, "instr_ready", int'(a.ready), int'(e.ready));
        if (e.chk_alu) cmp(tag, "alu_control", int'(a.alu), int'(e.alu));
        cmp(tag, "regwrite_control", int'(a.rw), int'(e.rw));
        cmp(tag, "illegal_instr", int'(a.ill), int'(e.ill));
        cmp(tag, "done", int'(a.done), int'(e.done));
        cmp(tag, "busy", int'(a.busy), int'(e.busy));
        cmp(tag, "acc_en", int'(a.en), int'(e.en));
        cmp(tag, "acc_clear", int'(a.clr), int'(e.clr));
        if (e.chk_idx) begin
            cmp(tag, "tap_index", a.tap, e.tap);
            cmp(tag, "ch_index", a.ch, e.ch);
        end
    endtask

    // Pop the oldest expectation and compare it against the chosen instance.
    task automatic pop_check(input string tag, input int which);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.queue: got empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_rec(tag, obs(which), e);
        end
    endtask

    // Run-time guard so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // R-type vectors: expected alu for illegal entries is the previous code.
        vt[0]  = '{RTYPE,   3'd0, 7'd0,  4'b0010, 1'b0};  // ADD
        vt[1]  = '{RTYPE,   3'd0, 7'd32, 4'b0100, 1'b0};  // SUB
        vt[2]  = '{RTYPE,   3'd1, 7'd0,  4'b0011, 1'b0};  // SLL
        vt[3]  = '{RTYPE,   3'd2, 7'd0,  4'b0110, 1'b0};  // MUL
        vt[4]  = '{RTYPE,   3'd4, 7'd0,  4'b0111, 1'b0};  // XOR
        vt[5]  = '{RTYPE,   3'd5, 7'd0,  4'b0101, 1'b0};  // SRL
        vt[6]  = '{RTYPE,   3'd5, 7'd32, 4'b1000, 1'b0};  // SRA
        vt[7]  = '{RTYPE,   3'd1, 7'd32, 4'b1000, 1'b1};  // illegal SLL/f7=32
        vt[8]  = '{RTYPE,   3'd6, 7'd0,  4'b0001, 1'b0};  // OR
        vt[9]  = '{7'b0000011, 3'd0, 7'd0, 4'b0001, 1'b1}; // unknown opcode
        vt[10] = '{CONV,    3'd1, 7'd0,  4'b0001, 1'b1};  // conv with bad funct3
        vt[11] = '{RTYPE,   3'd7, 7'd0,  4'b0000, 1'b0};  // AND
        vt[12] = '{RTYPE,   3'd0, 7'd0,  4'b0010, 1'b0};  // ADD
        vt[13] = '{RTYPE,   3'd2, 7'd32, 4'b0010, 1'b1};  // illegal MUL/f7=32

        reset = 1'b1;
        v0 = 1'b0; op0 = '0; f3_0 = '0; f7_0 = '0;
        v1 = 1'b0; op1 = '0; f3_1 = '0; f7_1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values; instr_ready is low while reset is asserted.
        exp_q.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        pop_check("reset0", 0);
        exp_q.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        pop_check("reset1", 1);
        reset = 1'b0;
        #1;
        cmp("post_reset", "instr_ready", int'(rdy0), 1);

        // Back-to-back table issue, one instruction per cycle.
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) pop_check($sformatf("vec%0d", i - 1), 0);
            if (i < NV) begin
                op0 = vt[i].op; f3_0 = vt[i].f3; f7_0 = vt[i].f7; v0 = 1'b1;
                exp_q.push_back(mk(1, vt[i].alu, 1, !vt[i].ill, vt[i].ill, 0, 0, 0, 0, 0, 0, 0));
                @(negedge clk);
            end else begin
                v0 = 1'b0;
            end
        end
        exp_q.push_back(mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        pop_check("after_table", 0);

        // Convolution 9x2 with an ADD held on the inputs throughout.
        op0 = CONV; f3_0 = 3'd0; f7_0 = 7'd0; v0 = 1'b1;
        for (int k = 1; k <= 18; k++)
            exp_q.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 1, (k == 1), 1, (k - 1) % 9, (k - 1) / 9));
        exp_q.push_back(mk(0, 4'b1111, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));  // CONV_WB
        exp_q.push_back(mk(1, 4'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // ready again
        exp_q.push_back(mk(1, 4'b0010, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // held ADD writes
        exp_q.push_back(mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // single pulse
        @(negedge clk);
        op0 = RTYPE; f3_0 = 3'd0; f7_0 = 7'd0;
        for (int k = 1; k <= 22; k++) begin
            pop_check($sformatf("conv_c%0d", k), 0);
            if (k == 21) v0 = 1'b0;
            @(negedge clk);
        end

        // Reset during the 5th accumulate cycle aborts the sequence.
        op0 = CONV; f3_0 = 3'd0; f7_0 = 7'd0; v0 = 1'b1;
        for (int k = 1; k <= 5; k++)
            exp_q.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 1, (k == 1), 1, k - 1, 0));
        @(negedge clk);
        v0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pop_check($sformatf("abort_c%0d", k), 0);
            if (k < 5) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        pop_check("abort_reset", 0);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            exp_q.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            pop_check($sformatf("abort_quiet%0d", k), 0);
        end

        // Single-position convolution on the 1x1 instance.
        @(negedge clk);
        op1 = CONV; f3_1 = 3'd0; f7_1 = 7'd0; v1 = 1'b1;
        exp_q.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0));
        exp_q.push_back(mk(0, 4'b1111, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 4'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 4'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        v1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pop_check($sformatf("k1_c%0d", k), 1);
            @(negedge clk);
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_control_seq.md
# conv_control_seq

Parametrised multi-cycle control unit for the convolution datapath. Decodes R-type and custom-convolution instructions into ALU control and register-write strobes. R-type instructions take one cycle. The convolution instruction becomes a counted sequence over `KERNEL_TAPS × NUM_CH` accumulate cycles followed by a single write-back, and the front end is stalled through a ready handshake. Sits between the instruction fetch unit (IFU) and the ALU/register file.

## Interface
- `KERNEL_TAPS`, 9: taps per channel; must be ≥1.
- `NUM_CH`, 1: input channels; must be ≥1.
- `CONV_OPCODE`, 7'b0001011: custom convolution opcode.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: decode fields are valid.
- `opcode` in 7, `funct3` in 3, `funct7` in 7: instruction fields.
- `instr_ready` out 1: instruction is accepted when `instr_valid & instr_ready`.
- `alu_control` out 4: ALU operation code.
- `regwrite_control` out 1: one-cycle register-file write strobe.
- `acc_clear` out 1: clear the convolution accumulator.
- `acc_en` out 1: accumulate this cycle.
- `tap_index` out TAP_W: current tap, where TAP_W = max(1, clog2(KERNEL_TAPS)).
- `ch_index` out CH_W: current channel, where CH_W = max(1, clog2(NUM_CH)).
- `busy` out 1: a convolution sequence is in progress.
- `done` out 1: one-cycle pulse on the convolution write-back.
- `illegal_instr` out 1: one-cycle pulse for an undecodable instruction.

## Operation
- States:
  - IDLE: the only state that can accept an instruction.
  - CONV_RUN: accumulate cycles.
  - CONV_WB: write-back cycle.
- All outputs are registered except `instr_ready`, which is 1 exactly when state is IDLE and `reset` is low.
- Reset values: state IDLE, `alu_control` 4'b0000, every strobe 0, `tap_index` 0, `ch_index` 0, `busy` 0.
- R-type decode (opcode 7'b0110011), with funct7 = 0 unless noted:
  - f3=0: ADD 0010
  - f3=0, f7=32: SUB 0100
  - f3=1: SLL 0011
  - f3=2: MUL 0110
  - f3=4: XOR 0111
  - f3=5: SRL 0101
  - f3=5, f7=32: SRA 1000 (new code)
  - f3=6: OR 0001
  - f3=7: AND 0000
- Legal R-type accepted in IDLE:
  - Next cycle: `alu_control` = code and `regwrite_control` = 1 for one cycle.
  - State stays IDLE, so back-to-back issue is allowed.
- Convolution: opcode = CONV_OPCODE, f3 = 0, f7 = 0.
  - On acceptance, go to CONV_RUN with `tap_index` = 0, `ch_index` = 0, `busy` = 1.
  - Each CONV_RUN cycle drives `acc_en` = 1.
  - `acc_clear` = 1 only on the first CONV_RUN cycle. When both are set, the accumulator loads the product and discards the old value.
  - `tap_index` increments every cycle. At KERNEL_TAPS−1 it wraps to 0 and `ch_index` increments.
  - After the cycle with tap = KERNEL_TAPS−1 and ch = NUM_CH−1, go to CONV_WB.
  - CONV_WB: `alu_control` = 4'b1111, `regwrite_control` = 1, `done` = 1, `busy` = 1, `acc_en` = 0. Return to IDLE.
- Any other accepted opcode/funct combination:
  - `illegal_instr` = 1 next cycle.
  - `regwrite_control` = 0; `alu_control` holds its previous value.
  - State stays IDLE.
- Outside the CONV sequence, `alu_control` holds its last value.
- `instr_valid` is ignored while `instr_ready` = 0. The source must hold the instruction.
- `reset` mid-sequence: the next cycle is IDLE with all reset values. No write-back and no `done`.
- `KERNEL_TAPS` = `NUM_CH` = 1: a single CONV_RUN cycle with both `acc_clear` and `acc_en` set, then CONV_WB.

## Timing
- R-type: accept at edge T; `regwrite_control` high during cycle T+1. Latency 1, throughput 1 per cycle.
- Convolution with N = KERNEL_TAPS·NUM_CH:
  - Accept at edge T.
  - CONV_RUN cycles T+1 … T+N.
  - CONV_WB at T+N+1.
  - `instr_ready` high again at T+N+2.
  - Total occupancy N+2 cycles.
- `tap_index` and `ch_index` are valid in every cycle where `acc_en` = 1.
- `illegal_instr`, `done` and `regwrite_control` never stay high for two consecutive cycles because of the same instruction.

## Structure
- Shared package `conv_ctrl_pkg`:
  - opcode constants (R-type, CONV default);
  - the 4-bit ALU code constants, including SRA 1000 and CONV 1111;
  - the state enum {IDLE, CONV_RUN, CONV_WB}.
- Sub-module `conv_tap_counter`:
  - parametrised by KERNEL_TAPS and NUM_CH;
  - inputs: `clock`, `reset`, `start`, `step`;
  - outputs: `tap_index`, `ch_index`, `last`.
- The top level holds the decode logic, the FSM and the output registers.

## Test plan
- Reset, then issue ADD (f3=0, f7=0) followed immediately by SUB (f3=0, f7=32):
  - cycle 1: `alu_control` 0010 with `regwrite_control` = 1;
  - cycle 2: `alu_control` 0100 with `regwrite_control` = 1;
  - `instr_ready` stays 1 throughout.
- SRA (f3=5, f7=32) → `alu_control` 1000. R-type with f3=1, f7=32 → `illegal_instr` pulse, `regwrite_control` = 0, `alu_control` unchanged.
- Convolution with KERNEL_TAPS=9, NUM_CH=2:
  - 18 `acc_en` cycles, `acc_clear` on the first only;
  - `tap_index` runs 0..8 twice while `ch_index` goes 0 then 1;
  - CONV_WB at accept+19 with `alu_control` 1111, `regwrite_control` = 1, `done` = 1;
  - `instr_ready` returns at accept+20.
- During a convolution, hold an ADD on the inputs with `instr_valid` = 1. It is accepted only once `instr_ready` returns, and its `regwrite_control` follows the CONV_WB cycle by 2 cycles.
- Assert `reset` at the 5th CONV_RUN cycle:
  - next cycle: state IDLE, `busy` = 0, `tap_index` = 0, `instr_ready` = 1;
  - no `done` and no write-back afterwards.
- With KERNEL_TAPS=1, NUM_CH=1: a single cycle with both `acc_clear` and `acc_en` set, then `done`; total occupancy 3 cycles.
